// File: rtl/seq_pair_gen_pkg.sv
// Shared types and constants for the seq_pair_gen serial pattern transmitter.
package seq_pair_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        PAUSE
    } state_t;

    localparam logic [4:0] PATTERN   = 5'b01110;
    localparam int         EXP_CNT_W = 8;

    function automatic int idx_width(input int npair);
        return (npair > 1) ? $clog2(npair) : 1;
    endfunction

endpackage

// File: rtl/seq_pair_gen_if.sv
// Control/pattern/pair bus between a stimulus controller (master) and seq_pair_gen (slave).
interface seq_pair_gen_if #(
    parameter int SEQ_WIDTH = 24
);
    import seq_pair_pkg::*;

    localparam int IDX_W = idx_width(SEQ_WIDTH / 2);

    logic                 load;
    logic [SEQ_WIDTH-1:0] seq_in;
    logic                 start;
    logic                 hold;
    logic                 loop;
    logic                 A;
    logic                 B;
    logic                 valid;
    logic                 busy;
    logic                 done;
    logic [IDX_W-1:0]     pair_idx;
    logic [EXP_CNT_W-1:0] exp_cnt;

    modport master (
        output load, seq_in, start, hold, loop,
        input  A, B, valid, busy, done, pair_idx, exp_cnt
    );

    modport slave (
        input  load, seq_in, start, hold, loop,
        output A, B, valid, busy, done, pair_idx, exp_cnt
    );

endinterface

// File: rtl/seq_pair_gen_expect.sv
// Golden 01110 counter over the emitted A-then-B serial stream.
// Only built when SEQ_PAIR_GEN_EXPECT_EN is defined.
`ifdef SEQ_PAIR_GEN_EXPECT_EN
module seq_pair_expect
    import seq_pair_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 restart,
    input  logic                 valid,
    input  logic                 a,
    input  logic                 b,
    output logic [EXP_CNT_W-1:0] exp_cnt
);

    logic [3:0] hist;
    logic       hit;

    // Window ending at A, then window ending at B; both cannot match in one cycle.
    assign hit = ({hist, a} == PATTERN) || ({hist[2:0], a, b} == PATTERN);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hist    <= '0;
            exp_cnt <= '0;
        end else if (restart) begin
            hist    <= '0;
            exp_cnt <= '0;
        end else if (valid) begin
            hist <= {hist[1:0], a, b};
            if (hit && (exp_cnt != '1))
                exp_cnt <= exp_cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/seq_pair_gen.sv
// Serial test-pattern transmitter: plays a loaded word two bits per clock, MSB pair first.
// Optional golden 01110 counter enabled by SEQ_PAIR_GEN_EXPECT_EN.
module seq_pair_gen
    import seq_pair_pkg::*;
#(
    parameter int SEQ_WIDTH = 24
) (
    input  logic          clk,
    input  logic          clr,
    seq_pair_gen_if.slave bus
);

    localparam int               NPAIR   = SEQ_WIDTH / 2;
    localparam int               IDX_W   = idx_width(NPAIR);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NPAIR - 1);

    state_t               state;
    logic [SEQ_WIDTH-1:0] pattern;
    logic                 a_q, b_q, valid_q, busy_q, done_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     next_idx;
    logic [1:0]           next_pair, top_pair, head_pair;

    assign next_idx  = idx_q - IDX_W'(1);
    assign next_pair = pattern[{next_idx, 1'b0} +: 2];
    assign top_pair  = pattern[SEQ_WIDTH-1 -: 2];
    // First pair bypasses the register when load and start coincide.
    assign head_pair = bus.load ? bus.seq_in[SEQ_WIDTH-1 -: 2] : top_pair;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            pattern <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load)
                        pattern <= bus.seq_in;
                    if (bus.start) begin
                        state      <= SEND;
                        idx_q      <= TOP_IDX;
                        {a_q, b_q} <= head_pair;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                // PAUSE with hold released advances exactly like SEND.
                SEND, PAUSE: begin
                    if (bus.hold) begin
                        state   <= PAUSE;
                        valid_q <= 1'b0;
                    end else if (idx_q != '0) begin
                        state      <= SEND;
                        idx_q      <= next_idx;
                        {a_q, b_q} <= next_pair;
                        valid_q    <= 1'b1;
                    end else if (bus.loop) begin
                        state      <= SEND;
                        idx_q      <= TOP_IDX;
                        {a_q, b_q} <= top_pair;
                        valid_q    <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.A        = a_q;
    assign bus.B        = b_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pair_idx = idx_q;

`ifdef SEQ_PAIR_GEN_EXPECT_EN
    logic restart;
    assign restart = (state == IDLE) && bus.start;

    seq_pair_expect u_expect (
        .clk     (clk),
        .clr     (clr),
        .restart (restart),
        .valid   (valid_q),
        .a       (a_q),
        .b       (b_q),
        .exp_cnt (bus.exp_cnt)
    );
`else
    assign bus.exp_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pair_gen.sv
// Randomized self-checking bench for seq_pair_gen against a pair-stream reference model.
module tb_seq_pair_gen;
    import seq_pair_pkg::*;

    localparam int W  = 24;
    localparam int NP = W / 2;

    logic clk = 1'b0;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seq_pair_gen_if #(.SEQ_WIDTH(W))  bus   ();
    seq_pair_gen_if #(.SEQ_WIDTH(12)) bus12 ();

    seq_pair_gen #(.SEQ_WIDTH(W))  dut   (.clk(clk), .clr(clr), .bus(bus));
    seq_pair_gen #(.SEQ_WIDTH(12)) dut12 (.clk(clk), .clr(clr), .bus(bus12));

    // Reference model: pattern word, number of pairs emitted, emitted bit stream
    logic [W-1:0] m_reg;
    bit           m_busy, m_valid, m_done, m_a, m_b;
    int           m_n, m_idx, m_cnt;
    bit           stream[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_or0(input int v);
`ifdef SEQ_PAIR_GEN_EXPECT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Overlapping 01110 occurrences in the stream since start, preceded by zeros, capped at 255
    function automatic int count_pat();
        logic [4:0] w = '0;
        int c = 0;
        foreach (stream[i]) begin
            w = {w[3:0], stream[i]};
            if (w == 5'b01110) c++;
        end
        return (c > 255) ? 255 : c;
    endfunction

    task automatic model_reset();
        m_reg = '0; m_busy = 0; m_valid = 0; m_done = 0;
        m_a = 0; m_b = 0; m_n = 0; m_idx = 0; m_cnt = 0;
        stream.delete();
    endtask

    task automatic emit();
        int k = NP - 1 - (m_n % NP);
        m_a = m_reg[2*k+1];
        m_b = m_reg[2*k];
        m_idx = k;
        stream.push_back(m_a);
        stream.push_back(m_b);
        m_n++;
        m_valid = 1;
    endtask

    task automatic model_step(input bit ld, input logic [W-1:0] sq, input bit st, input bit hd, input bit lp);
        int new_cnt = m_cnt;
        if (m_valid) new_cnt = count_pat();
        m_done = 0;
        if (!m_busy) begin
            if (ld) m_reg = sq;
            if (st) begin
                m_busy = 1; m_n = 0; stream.delete(); new_cnt = 0;
                emit();
            end
        end else if (hd) begin
            m_valid = 0;
        end else if ((m_n % NP == 0) && !lp) begin
            m_busy = 0; m_valid = 0; m_done = 1;
        end else begin
            emit();
        end
        m_cnt = new_cnt;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".A"},     32'(bus.A),        32'(m_a));
        check_eq({tag, ".B"},     32'(bus.B),        32'(m_b));
        check_eq({tag, ".valid"}, 32'(bus.valid),    32'(m_valid));
        check_eq({tag, ".busy"},  32'(bus.busy),     32'(m_busy));
        check_eq({tag, ".done"},  32'(bus.done),     32'(m_done));
        check_eq({tag, ".idx"},   32'(bus.pair_idx), m_idx);
        check_eq({tag, ".exp"},   32'(bus.exp_cnt),  exp_or0(m_cnt));
    endtask

    task automatic cycle(input string tag, input bit ld, input logic [W-1:0] sq,
                         input bit st, input bit hd, input bit lp);
        bus.load = ld; bus.seq_in = sq; bus.start = st; bus.hold = hd; bus.loop = lp;
        model_step(ld, sq, st, hd, lp);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // mode 0: load then start, 1: load+start together, 2: start only
    task automatic run_play(input string tag, input logic [W-1:0] pat, input int mode,
                            input int hold_idx, input int hold_len, input int wraps,
                            input int hold_pct, input bit noise, output int nvalid);
        int  hold_left = 0;
        bit  held = 0;
        bit  hd, ld, st;
        nvalid = 0;
        if (mode == 0) cycle({tag, ".ld"}, 1, pat, 0, 0, 0);
        cycle({tag, ".st"}, mode != 2, pat, 1, 0, 0);
        nvalid += int'(bus.valid);
        for (int c = 0; c < 300 && m_busy; c++) begin
            if (!held && bus.valid && int'(bus.pair_idx) == hold_idx) begin
                hold_left = hold_len;
                held = 1;
            end
            hd = (hold_left > 0) || ($urandom_range(0, 99) < hold_pct);
            if (hold_left > 0) hold_left--;
            ld = noise && ($urandom_range(0, 3) == 0);
            st = noise && ($urandom_range(0, 3) == 0);
            cycle(tag, ld, W'($urandom()), st, hd, m_n < NP * (wraps + 1));
            nvalid += int'(bus.valid);
        end
        check_eq({tag, ".finished"}, 32'(bus.busy), 32'd0);
        cycle({tag, ".idle"}, 0, '0, 0, 0, 0);
    endtask

    logic [W-1:0]  v1 = 24'b011101110111001110001110;
    logic [11:0]   p12 = 12'b011101110000;
    int            v1_pairs[NP] = '{1, 3, 1, 3, 1, 3, 0, 3, 2, 0, 3, 2};

    initial begin
        int nv;
        bus.load = 0; bus.seq_in = '0; bus.start = 0; bus.hold = 0; bus.loop = 0;
        bus12.load = 0; bus12.seq_in = '0; bus12.start = 0; bus12.hold = 0; bus12.loop = 0;
        clr = 1'b0;
        #1 clr = 1'b1;
        #1;
        model_reset();
        compare_all("reset");
        @(posedge clk);
        #1 clr = 1'b0;

        // Reference vector with explicit pair list
        cycle("v1.ld", 1, v1, 0, 0, 0);
        cycle("v1.st", 0, '0, 1, 0, 0);
        for (int i = 0; i < NP; i++) begin
            check_eq("v1.pair", 32'({bus.A, bus.B}), v1_pairs[i]);
            check_eq("v1.pidx", 32'(bus.pair_idx), NP - 1 - i);
            cycle("v1", 0, '0, 0, 0, 0);
        end
        check_eq("v1.done", 32'(bus.done), 32'd1);
        check_eq("v1.exp5", 32'(bus.exp_cnt), exp_or0(5));
        cycle("v1.after", 0, '0, 0, 0, 0);

        // Hold three cycles at idx 8, still twelve valid pairs
        run_play("hold", v1, 1, 8, 3, 0, 0, 0, nv);
        check_eq("hold.nvalid", nv, NP);

        // One loop wrap then finish; count keeps accumulating
        run_play("loop", v1, 0, -1, 0, 1, 0, 0, nv);
        check_eq("loop.nvalid", nv, 2 * NP);
        check_eq("loop.exp10", 32'(bus.exp_cnt), exp_or0(10));

        // Pulses on load/start while busy are ignored
        run_play("noise", v1, 0, -1, 0, 0, 0, 1, nv);
        check_eq("noise.nvalid", nv, NP);

        // Asynchronous clear mid-playback, then start without load sends zeros
        cycle("clr.st", 1, v1, 1, 0, 0);
        for (int c = 0; c < 20 && !(bus.valid && bus.pair_idx == 5); c++)
            cycle("clr.run", 0, '0, 0, 0, 0);
        check_eq("clr.reach5", 32'(bus.pair_idx), 32'd5);
        clr = 1'b1;
        #1;
        model_reset();
        compare_all("clr.async");
        #2 clr = 1'b0;
        run_play("zeros", '0, 2, -1, 0, 0, 0, 0, nv);
        check_eq("zeros.nvalid", nv, NP);

        // Randomized playback: patterns, holds, wraps, busy-time noise
        for (int r = 0; r < 25; r++)
            run_play("rand", W'($urandom()), $urandom_range(0, 2), $urandom_range(0, NP - 1),
                     $urandom_range(0, 3), $urandom_range(0, 2), 25, 1, nv);

        // 12-bit instance with load bypass
        bus12.load = 1; bus12.seq_in = p12; bus12.start = 1;
        @(posedge clk);
        #1 bus12.load = 0; bus12.start = 0;
        for (int k = 5; k >= 0; k--) begin
            check_eq("w12.valid", 32'(bus12.valid), 32'd1);
            check_eq("w12.A", 32'(bus12.A), 32'(p12[2*k+1]));
            check_eq("w12.B", 32'(bus12.B), 32'(p12[2*k]));
            check_eq("w12.idx", 32'(bus12.pair_idx), k);
            @(posedge clk);
            #1;
        end
        check_eq("w12.done", 32'(bus12.done), 32'd1);
        check_eq("w12.busy", 32'(bus12.busy), 32'd0);
        check_eq("w12.exp2", 32'(bus12.exp_cnt), exp_or0(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
